cdc_fifo_rdrain: RTL and testbench
==================================

Name: cdc_fifo_rdrain

Overview:
- Read-side consumer for the 1-deep/2-register CDC FIFO synchronizer; lives entirely in the read clock domain.
- Pops words from the FIFO read port (rdata/rrdy/rget) into a 2-entry skid buffer.
- Presents the words on a registered valid/ready stream to downstream logic.
- Provides a flush/discard control and saturating accept/drop counters for debug.

Parameters:
dat_t, logic [7:0], payload type; must match the FIFO's dat_t
CNT_W, 16, width of the pop_cnt and drop_cnt counters

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  reset, synchronous, active-low
fifo_rdata  input  dat_t  FIFO read data; valid only while fifo_rrdy=1
fifo_rrdy  input  1  FIFO holds an unread word
fifo_rget  output  1  pop request; the FIFO pops on an rclk edge where fifo_rrdy&fifo_rget
m_data  output  dat_t  downstream data (head of skid buffer)
m_valid  output  1  downstream valid
m_ready  input  1  downstream ready
flush  input  1  discard buffered words and drain the FIFO while high
pop_cnt  output  CNT_W  words accepted into the buffer, saturating
drop_cnt  output  CNT_W  words discarded by flush, saturating

Behaviour:
- Single clock rclk. Reset is synchronous and active-low on rrst_n; all state is cleared on an rclk edge with rrst_n=0.
- Reset values: occupancy EMPTY, both buffer entries '0, pop_cnt=0, drop_cnt=0. Outputs after reset: m_valid=0, m_data='0, fifo_rget=1.
- Reset mid-operation: any buffered words are lost and not counted. The FIFO itself is reset independently.
- FSM on occupancy has three states: EMPTY, ONE, TWO. Entry 0 is always the head, and m_data = entry0.
- Combinational terms:
  - fifo_rget = flush | (state != TWO). This depends only on flush and state, with no path from m_ready.
  - take = fifo_rrdy & fifo_rget & ~flush
  - drop = fifo_rrdy & flush
  - pop = m_valid & m_ready
  - m_valid = (state != EMPTY) & ~flush
- Transitions when flush=0:
  - EMPTY: take -> ONE; entry0 <= fifo_rdata.
  - ONE:
    - take & pop -> stay ONE; entry0 <= fifo_rdata.
    - take & ~pop -> TWO; entry1 <= fifo_rdata.
    - ~take & pop -> EMPTY.
    - otherwise hold.
  - TWO (take=0 by construction): pop -> ONE; entry0 <= entry1. Otherwise hold.
- Flush: on any edge with flush=1, state <= EMPTY, entries hold their contents (don't-care), and no take occurs.
  - m_valid is forced low combinationally during flush. This is the only permitted case of valid dropping without ready.
- Latency: a word arriving at fifo_rrdy in cycle N with state EMPTY or ONE is taken at the end of cycle N. It appears on m_valid/m_data in cycle N+1 when it is the head.
- Ordering: strict FIFO order. No word is duplicated or lost unless flush is asserted.
- Simultaneous take and pop in ONE gives sustained throughput. The upstream FIFO limits the rate to 1 word per sync round trip.
- Counters:
  - pop_cnt += 1 on take; drop_cnt += 1 on drop.
  - Both saturate at all-ones and never wrap. Each counts at most one per cycle.
- m_data is don't-care while m_valid=0. Downstream must not sample it then.

Decomposition:
- Shared package cdc_pkg holds:
  - the occupancy enum occ_e {EMPTY, ONE, TWO}
  - the default payload typedef
  - a saturating-increment function reused for both counters.
- One natural sub-module, cdc_skid2: the 2-entry buffer plus FSM with take/pop/clr inputs.
- Counters and fifo_rget logic stay in the top module.

Test Plan:
- Reset: hold rrst_n=0 for 3 rclk with fifo_rrdy=1 -> m_valid=0, pop_cnt=0, drop_cnt=0, fifo_rget=1. Release -> word 0xA5 is taken next edge, m_valid=1 with m_data=0xA5 one cycle later.
- Backpressure: m_ready=0 while the FIFO presents 0x11 then 0x22 -> state TWO, fifo_rget=0, m_data stays 0x11. Raise m_ready -> outputs 0x11 then 0x22 in consecutive cycles, then m_valid=0; pop_cnt=2.
- Streaming: m_ready=1 with 8 FIFO words 0x00..0x07 -> outputs appear in order with no gaps beyond FIFO rate; pop_cnt=8; state never reaches TWO.
- Flush: state TWO holding 0x33/0x44, assert flush 4 cycles while the FIFO presents 0x55 -> m_valid=0 throughout, 0x55 popped; drop_cnt=1, pop_cnt unchanged. After deassert, state EMPTY.
- Saturation: CNT_W=4, take 20 words -> pop_cnt stops at 15, data still flows correctly.
- Reset mid-operation: rrst_n=0 for 1 cycle in state TWO -> next cycle m_valid=0, state EMPTY, counters 0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the CDC FIFO read-side drain.
package cdc_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    typedef logic [7:0] dat_def_t;

    // Increment v, clamping at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : (v + 32'd1);
    endfunction

endpackage

// File: rtl/cdc_skid2.sv
// Two-entry skid buffer with occupancy FSM; entry 0 is always the head.
module cdc_skid2
    import cdc_pkg::*;
#(
    parameter type dat_t = dat_def_t
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic take,
    input  logic pop,
    input  logic clr,
    input  dat_t din,
    output occ_e state,
    output dat_t head
);

    occ_e state_nxt;
    dat_t e0, e1;
    dat_t e0_nxt, e1_nxt;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state <= EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            state <= state_nxt;
            e0    <= e0_nxt;
            e1    <= e1_nxt;
        end
    end

    // Occupancy transitions; flush wins over everything and leaves entries stale.
    always_comb begin
        state_nxt = state;
        e0_nxt    = e0;
        e1_nxt    = e1;
        if (clr) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (take) begin
                        state_nxt = ONE;
                        e0_nxt    = din;
                    end
                end
                ONE: begin
                    if (take && pop) begin
                        e0_nxt = din;
                    end else if (take) begin
                        state_nxt = TWO;
                        e1_nxt    = din;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt = ONE;
                        e0_nxt    = e1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign head = e0;

endmodule

// File: rtl/cdc_fifo_rdrain.sv
// Read-domain consumer of the CDC FIFO: pops into a skid buffer, streams out
// on valid/ready, supports flush, and keeps saturating accept/drop counters.
module cdc_fifo_rdrain
    import cdc_pkg::*;
#(
    parameter type         dat_t = dat_def_t,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  dat_t             fifo_rdata,
    input  logic             fifo_rrdy,
    output logic             fifo_rget,
    output dat_t             m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] pop_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    occ_e state;
    logic take;
    logic drop;
    logic pop;

    // rget depends only on flush and occupancy so ready never loops back upstream.
    assign fifo_rget = flush | (state != TWO);
    assign take      = fifo_rrdy & fifo_rget & ~flush;
    assign drop      = fifo_rrdy & flush;
    assign m_valid   = (state != EMPTY) & ~flush;
    assign pop       = m_valid & m_ready;

    cdc_skid2 #(
        .dat_t(dat_t)
    ) u_skid (
        .rclk  (rclk),
        .rrst_n(rrst_n),
        .take  (take),
        .pop   (pop),
        .clr   (flush),
        .din   (fifo_rdata),
        .state (state),
        .head  (m_data)
    );

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            pop_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (take) begin
                pop_cnt <= CNT_W'(sat_inc(32'(pop_cnt), CNT_W));
            end
            if (drop) begin
                drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_cdc_fifo_rdrain.sv
// Randomised and directed bench for cdc_fifo_rdrain against a queue-based model.
module tb_cdc_fifo_rdrain;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [7:0] fifo_rdata;
    logic       fifo_rrdy;
    logic       m_ready;
    logic       flush;

    logic        fifo_rget_a, m_valid_a;
    logic [7:0]  m_data_a;
    logic [15:0] pop_cnt_a, drop_cnt_a;
    logic        fifo_rget_b, m_valid_b;
    logic [7:0]  m_data_b;
    logic [3:0]  pop_cnt_b, drop_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  q[$];
    logic [7:0]  src[$];
    int unsigned n_take, n_drop;

    always #5 rclk = ~rclk;

    cdc_fifo_rdrain #(.CNT_W(16)) dut_a (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rrdy(fifo_rrdy),
        .fifo_rget(fifo_rget_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .flush(flush), .pop_cnt(pop_cnt_a), .drop_cnt(drop_cnt_a)
    );

    cdc_fifo_rdrain #(.CNT_W(4)) dut_b (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rrdy(fifo_rrdy),
        .fifo_rget(fifo_rget_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .flush(flush), .pop_cnt(pop_cnt_b), .drop_cnt(drop_cnt_b)
    );

    function automatic logic exp_rget();
        return flush || (q.size() < 2);
    endfunction

    function automatic logic exp_valid();
        return (q.size() > 0) && !flush;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned w);
        int unsigned lim;
        lim = (32'd1 << w) - 32'd1;
        return (n > lim) ? lim : n;
    endfunction

    // Apply one cycle of inputs; the upstream FIFO presents src[0] unless held off.
    task automatic drive(input logic fl, input logic rdy, input bit hold);
        flush      = fl;
        m_ready    = rdy;
        fifo_rrdy  = (src.size() > 0) && !hold;
        fifo_rdata = (src.size() > 0) ? src[0] : 8'($urandom);
        #1;
    endtask

    // Advance one rclk edge and update the reference model from pre-edge inputs.
    task automatic tick();
        bit tk, dp, pp, up;
        logic [7:0] d;
        tk = fifo_rrdy && exp_rget() && !flush;
        dp = fifo_rrdy && flush;
        pp = exp_valid() && m_ready;
        up = fifo_rrdy && exp_rget() && rrst_n;
        d  = fifo_rdata;
        @(posedge rclk);
        if (up) void'(src.pop_front());
        if (!rrst_n) begin
            q.delete();
            n_take = 0;
            n_drop = 0;
        end else if (flush) begin
            q.delete();
            if (dp) n_drop++;
        end else begin
            if (pp) void'(q.pop_front());
            if (tk) begin
                q.push_back(d);
                n_take++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        src.delete();
        rrst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        src.delete();
        src.push_back(8'hA5);
        rrst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({m_valid_a, m_data_a, fifo_rget_a, pop_cnt_a, drop_cnt_a} !== {1'b1 ^ 1'b1, 8'h00, 1'b1, 16'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%h rget=%b pop=%0d drop=%0d, want 0 00 1 0 0",
                     m_valid_a, m_data_a, fifo_rget_a, pop_cnt_a, drop_cnt_a);
        end
        rrst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({m_valid_a, fifo_rget_a} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b rget=%b, want 0 1", m_valid_a, fifo_rget_a);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({m_valid_a, m_data_a} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL reset_first_word: valid=%b data=%h, want 1 a5", m_valid_a, m_data_a);
        end
        vectors++;
        if (pop_cnt_a !== 16'd1) begin
            miscompares++;
            $display("FAIL reset_first_cnt: pop_cnt=%0d, want 1", pop_cnt_a);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        src.push_back(8'h11);
        src.push_back(8'h22);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({m_valid_a, m_data_a} !== {1'b1, 8'h11}) begin
            miscompares++;
            $display("FAIL bp_one: valid=%b data=%h, want 1 11", m_valid_a, m_data_a);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            vectors++;
            if ({fifo_rget_a, m_valid_a, m_data_a} !== {1'b0, 1'b1, 8'h11}) begin
                miscompares++;
                $display("FAIL bp_full: rget=%b valid=%b data=%h, want 0 1 11", fifo_rget_a, m_valid_a, m_data_a);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({m_valid_a, m_data_a} !== {1'b1, 8'h11}) begin
            miscompares++;
            $display("FAIL bp_out0: valid=%b data=%h, want 1 11", m_valid_a, m_data_a);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({m_valid_a, m_data_a} !== {1'b1, 8'h22}) begin
            miscompares++;
            $display("FAIL bp_out1: valid=%b data=%h, want 1 22", m_valid_a, m_data_a);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({m_valid_a, pop_cnt_a} !== {1'b0, 16'd2}) begin
            miscompares++;
            $display("FAIL bp_drained: valid=%b pop_cnt=%0d, want 0 2", m_valid_a, pop_cnt_a);
        end
    endtask

    task automatic test_streaming();
        int got;
        int cycles;
        do_reset();
        for (int i = 0; i < 8; i++) src.push_back(8'(i));
        got = 0;
        cycles = 0;
        while (got < 8 && cycles < 40) begin
            drive(1'b0, 1'b1, 1'b0);
            vectors++;
            if (fifo_rget_a !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_rget: rget=%b in cycle %0d, want 1", fifo_rget_a, cycles);
            end
            if (got > 0 && !m_valid_a) begin
                miscompares++;
                $display("FAIL stream_gap: valid=0 after %0d words, want 1", got);
            end
            if (m_valid_a) begin
                vectors++;
                if (m_data_a !== 8'(got)) begin
                    miscompares++;
                    $display("FAIL stream_data: data=%h, want %h", m_data_a, 8'(got));
                end
                got++;
            end
            tick();
            cycles++;
        end
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if (got != 8 || pop_cnt_a !== 16'd8) begin
            miscompares++;
            $display("FAIL stream_count: words=%0d pop_cnt=%0d, want 8 8", got, pop_cnt_a);
        end
    endtask

    task automatic test_flush();
        do_reset();
        src.push_back(8'h33);
        src.push_back(8'h44);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({fifo_rget_a, m_valid_a, m_data_a} !== {1'b0, 1'b1, 8'h33}) begin
            miscompares++;
            $display("FAIL flush_pre: rget=%b valid=%b data=%h, want 0 1 33", fifo_rget_a, m_valid_a, m_data_a);
        end
        src.push_back(8'h55);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            vectors++;
            if ({m_valid_a, fifo_rget_a} !== 2'b01) begin
                miscompares++;
                $display("FAIL flush_active: valid=%b rget=%b in cycle %0d, want 0 1", m_valid_a, fifo_rget_a, i);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({m_valid_a, fifo_rget_a, drop_cnt_a, pop_cnt_a} !== {1'b0, 1'b1, 16'd1, 16'd2}) begin
            miscompares++;
            $display("FAIL flush_post: valid=%b rget=%b drop=%0d pop=%0d, want 0 1 1 2",
                     m_valid_a, fifo_rget_a, drop_cnt_a, pop_cnt_a);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] stream[$];
        int cycles;
        do_reset();
        for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
        stream = src;
        cycles = 0;
        while (stream.size() > 0 && cycles < 300) begin
            drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            if (m_valid_a) begin
                vectors++;
                if (m_data_a !== stream[0] || m_data_b !== stream[0] || m_valid_b !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sat_data: a=%h b=%h vb=%b, want %h", m_data_a, m_data_b, m_valid_b, stream[0]);
                end
                if (m_ready) void'(stream.pop_front());
            end
            tick();
            cycles++;
        end
        drive(1'b0, 1'b0, 1'b1);
        vectors++;
        if (stream.size() != 0 || pop_cnt_b !== 4'hF || pop_cnt_a !== 16'd20) begin
            miscompares++;
            $display("FAIL sat_count: left=%0d pop_b=%0d pop_a=%0d, want 0 15 20",
                     stream.size(), pop_cnt_b, pop_cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        src.push_back(8'h66);
        src.push_back(8'h77);
        src.push_back(8'h88);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (fifo_rget_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_full: rget=%b, want 0", fifo_rget_a);
        end
        rrst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        rrst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        vectors++;
        if ({m_valid_a, fifo_rget_a, pop_cnt_a, drop_cnt_a, pop_cnt_b} !== {1'b0, 1'b1, 16'd0, 16'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL rmid_state: valid=%b rget=%b pop=%0d drop=%0d popb=%0d, want 0 1 0 0 0",
                     m_valid_a, fifo_rget_a, pop_cnt_a, drop_cnt_a, pop_cnt_b);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (src.size() < 3 && $urandom_range(0, 1) == 1) src.push_back(8'($urandom));
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            vectors++;
            if ({m_valid_a, fifo_rget_a, m_valid_b, fifo_rget_b} !== {exp_valid(), exp_rget(), exp_valid(), exp_rget()}) begin
                miscompares++;
                $display("FAIL rand_ctrl: cyc=%0d valid=%b/%b rget=%b/%b, want %b %b",
                         c, m_valid_a, m_valid_b, fifo_rget_a, fifo_rget_b, exp_valid(), exp_rget());
            end
            if (exp_valid()) begin
                vectors++;
                if (m_data_a !== q[0] || m_data_b !== q[0]) begin
                    miscompares++;
                    $display("FAIL rand_data: cyc=%0d data=%h/%h, want %h", c, m_data_a, m_data_b, q[0]);
                end
            end
            vectors++;
            if ({pop_cnt_a, drop_cnt_a, pop_cnt_b, drop_cnt_b} !==
                {16'(sat(n_take, 16)), 16'(sat(n_drop, 16)), 4'(sat(n_take, 4)), 4'(sat(n_drop, 4))}) begin
                miscompares++;
                $display("FAIL rand_cnt: cyc=%0d pop=%0d/%0d drop=%0d/%0d, want takes=%0d drops=%0d",
                         c, pop_cnt_a, pop_cnt_b, drop_cnt_a, drop_cnt_b, n_take, n_drop);
            end
            tick();
        end
    endtask

    initial begin
        rrst_n     = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_rrdy  = 1'b0;
        fifo_rdata = 8'h00;
        n_take     = 0;
        n_drop     = 0;
        @(posedge rclk);
        #1;
        test_reset();
        test_backpressure();
        test_streaming();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
